// File: rtl/board_row_fetcher.sv
// Fetches one board row from RAM, overlays the falling piece, and commits all cells at once.
// Latency: 13 cycles from the sampled LD_Row rising edge to rowReady (2 cycles for an off-board blank row).
// Backpressure: none; LD_Row rising edges seen while busy are dropped, and a held-high level never retriggers.
module board_row_fetcher #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 20
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        LD_Row,
  input  logic [7:0]  rowNum,
  output logic [7:0]  ram_addr,
  input  logic [15:0] ram_data,
  input  logic        piece_valid,
  input  logic [3:0]  piece_x [4],
  input  logic [4:0]  piece_y [4],
  input  logic [15:0] piece_color,
  output logic [15:0] Row [BOARD_W],
  output logic        rowReady
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, COMMIT} state_t;

  localparam logic [7:0] W8       = 8'(BOARD_W);
  localparam logic [7:0] H8       = 8'(BOARD_H);
  localparam logic [3:0] LAST_COL = 4'(BOARD_W - 1);

  state_t             state;
  state_t             state_nxt;
  logic               ld_prev;
  logic               start;
  logic [7:0]         cur_row;
  logic [3:0]         col;
  logic [15:0]        shadow [BOARD_W];
  logic [BOARD_W-1:0] hit;

  // Only a fresh rising edge while idle starts a row; anything else is ignored.
  assign start = LD_Row && !ld_prev && (state == IDLE);

  // State register.
  always_ff @(posedge Clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic and RAM address generation.
  always_comb begin
    state_nxt = state;
    ram_addr  = '0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (rowNum < H8) ? FETCH : COMMIT;
      end
      FETCH: begin
        ram_addr = cur_row * W8 + {4'b0000, col};
        if (col == LAST_COL) state_nxt = DRAIN;
      end
      DRAIN:   state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-column piece hit; piece_x values past the last column never match.
  always_comb begin
    hit = '0;
    for (int x = 0; x < BOARD_W; x++) begin
      for (int i = 0; i < 4; i++) begin
        if (piece_valid && (piece_x[i] == 4'(x)) && ({3'b000, piece_y[i]} == cur_row))
          hit[x] = 1'b1;
      end
    end
  end

  // Datapath: edge history, row/column tracking, shadow capture and atomic commit.
  always_ff @(posedge Clk) begin
    if (reset) begin
      ld_prev  <= 1'b0;
      cur_row  <= '0;
      col      <= '0;
      rowReady <= 1'b0;
      for (int x = 0; x < BOARD_W; x++) begin
        shadow[x] <= '0;
        Row[x]    <= '0;
      end
    end else begin
      ld_prev  <= LD_Row;
      rowReady <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cur_row <= rowNum;
            col     <= '0;
            // Off-board rows commit as blank, so the shadow must be empty.
            if (rowNum >= H8) begin
              for (int x = 0; x < BOARD_W; x++) shadow[x] <= '0;
            end
          end
        end
        FETCH: begin
          // RAM data lags the address by one cycle, so it belongs to col-1.
          if (col != 4'd0) shadow[col - 4'd1] <= ram_data;
          col <= col + 4'd1;
        end
        DRAIN: shadow[LAST_COL] <= ram_data;
        COMMIT: begin
          for (int x = 0; x < BOARD_W; x++)
            Row[x] <= hit[x] ? piece_color : shadow[x];
          rowReady <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_board_row_fetcher.sv
// Directed bench for board_row_fetcher with a synchronous RAM model (cell = 16'h0100 + addr).
// Inputs are driven and outputs sampled on the falling clock edge.
// Cycle N below means N falling edges after the cycle in which LD_Row rose.
module tb_board_row_fetcher;

  logic        Clk = 1'b0;
  logic        reset;
  logic        LD_Row;
  logic [7:0]  rowNum;
  logic [7:0]  ram_addr;
  logic [15:0] ram_data;
  logic        piece_valid;
  logic [3:0]  piece_x [4];
  logic [4:0]  piece_y [4];
  logic [15:0] piece_color;
  logic [15:0] Row [10];
  logic        rowReady;

  int checks = 0;
  int errors = 0;

  board_row_fetcher dut (
    .Clk(Clk), .reset(reset), .LD_Row(LD_Row), .rowNum(rowNum),
    .ram_addr(ram_addr), .ram_data(ram_data), .piece_valid(piece_valid),
    .piece_x(piece_x), .piece_y(piece_y), .piece_color(piece_color),
    .Row(Row), .rowReady(rowReady)
  );

  always #5 Clk = ~Clk;

  // Synchronous board RAM: data appears the cycle after the address.
  always @(posedge Clk) ram_data <= 16'h0100 + {8'h00, ram_addr};

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; LD_Row = 1'b0; rowNum = 8'd0; piece_valid = 1'b0; piece_color = 16'h0;
    for (int i = 0; i < 4; i++) begin piece_x[i] = 4'd0; piece_y[i] = 5'd0; end
    step(3);
    reset = 1'b0;
    step(1);
    for (int x = 0; x < 10; x++) begin
      checks++;
      if (Row[x] !== 16'h0) begin errors++; $display("FAIL reset_row[%0d] got %h want 0000", x, Row[x]); end
    end
    checks++;
    if (ram_addr !== 8'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", ram_addr); end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (rowReady !== 1'b0) begin errors++; $display("FAIL reset_idle_ready cycle %0d got %b want 0", c, rowReady); end
      step(1);
    end
  endtask

  task automatic test_hold_high;
    int pulses = 0;
    rowNum = 8'd3; LD_Row = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      step(1);
      if (rowReady === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL hold_high_pulses got %0d want 1", pulses); end
    LD_Row = 1'b0; step(2);
  endtask

  task automatic test_fetch_row3;
    rowNum = 8'd3; LD_Row = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      step(1);
      if (c == 1) LD_Row = 1'b0;
      if (c <= 10) begin
        checks++;
        if (ram_addr !== 8'(29 + c)) begin errors++; $display("FAIL row3_addr cycle %0d got %0d want %0d", c, ram_addr, 29 + c); end
      end
      if (c == 12) begin
        checks++;
        if (rowReady !== 1'b0) begin errors++; $display("FAIL row3_early_ready got %b want 0", rowReady); end
      end
      if (c == 13) begin
        checks++;
        if (rowReady !== 1'b1) begin errors++; $display("FAIL row3_ready got %b want 1", rowReady); end
        for (int x = 0; x < 10; x++) begin
          checks++;
          if (Row[x] !== 16'(16'h011E + x)) begin errors++; $display("FAIL row3_cell[%0d] got %h want %h", x, Row[x], 16'(16'h011E + x)); end
        end
      end
      if (c == 14) begin
        checks++;
        if (rowReady !== 1'b0) begin errors++; $display("FAIL row3_ready_drop got %b want 0", rowReady); end
      end
    end
  endtask

  task automatic test_overlay;
    logic [15:0] exp;
    piece_valid = 1'b1; piece_color = 16'h0F00;
    piece_x[0] = 4'd2; piece_y[0] = 5'd5;
    piece_x[1] = 4'd3; piece_y[1] = 5'd5;
    piece_x[2] = 4'd4; piece_y[2] = 5'd5;
    piece_x[3] = 4'd3; piece_y[3] = 5'd6;
    rowNum = 8'd5; LD_Row = 1'b1;
    step(1); LD_Row = 1'b0;
    step(12);
    checks++;
    if (rowReady !== 1'b1) begin errors++; $display("FAIL overlay_ready got %b want 1", rowReady); end
    for (int x = 0; x < 10; x++) begin
      exp = (x >= 2 && x <= 4) ? 16'h0F00 : 16'(16'h0132 + x);
      checks++;
      if (Row[x] !== exp) begin errors++; $display("FAIL overlay_cell[%0d] got %h want %h", x, Row[x], exp); end
    end
    piece_valid = 1'b0;
    step(2);
  endtask

  task automatic test_blank;
    rowNum = 8'd20; LD_Row = 1'b1;
    step(1); LD_Row = 1'b0;
    checks++;
    if (ram_addr !== 8'd0 || rowReady !== 1'b0) begin errors++; $display("FAIL blank_c1 got addr %0d ready %b want 0 0", ram_addr, rowReady); end
    step(1);
    checks++;
    if (rowReady !== 1'b1) begin errors++; $display("FAIL blank_ready got %b want 1", rowReady); end
    checks++;
    if (ram_addr !== 8'd0) begin errors++; $display("FAIL blank_addr got %0d want 0", ram_addr); end
    for (int x = 0; x < 10; x++) begin
      checks++;
      if (Row[x] !== 16'h0) begin errors++; $display("FAIL blank_cell[%0d] got %h want 0000", x, Row[x]); end
    end
    step(2);
  endtask

  task automatic test_busy_drop;
    int pulses = 0;
    rowNum = 8'd3; LD_Row = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      step(1);
      if (rowReady === 1'b1 && c <= 14) pulses++;
      if (c == 1 || c == 6) LD_Row = 1'b0;
      if (c == 5 || c == 14) LD_Row = 1'b1;
      if (c == 13) begin
        checks++;
        if (rowReady !== 1'b1) begin errors++; $display("FAIL busy_ready got %b want 1", rowReady); end
      end
      if (c == 15) begin
        LD_Row = 1'b0;
        checks++;
        if (ram_addr !== 8'd30) begin errors++; $display("FAIL busy_restart_addr got %0d want 30", ram_addr); end
      end
    end
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL busy_pulses got %0d want 1", pulses); end
    step(15);
  endtask

  task automatic test_commit_edge;
    int pulses = 0;
    rowNum = 8'd3; LD_Row = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      step(1);
      if (rowReady === 1'b1) pulses++;
      if (c == 1) LD_Row = 1'b0;
      if (c == 12) LD_Row = 1'b1;
    end
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL commit_edge_pulses got %0d want 1", pulses); end
    LD_Row = 1'b0; step(2);
  endtask

  task automatic test_reset_mid;
    int pulses = 0;
    rowNum = 8'd4; LD_Row = 1'b1;
    step(1); LD_Row = 1'b0;
    step(5);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    checks++;
    if (ram_addr !== 8'd0 || rowReady !== 1'b0) begin errors++; $display("FAIL midreset_idle got addr %0d ready %b want 0 0", ram_addr, rowReady); end
    for (int x = 0; x < 10; x++) begin
      checks++;
      if (Row[x] !== 16'h0) begin errors++; $display("FAIL midreset_cell[%0d] got %h want 0000", x, Row[x]); end
    end
    for (int c = 0; c < 20; c++) begin
      if (rowReady === 1'b1) pulses++;
      step(1);
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL midreset_pulses got %0d want 0", pulses); end
  endtask

  initial begin
    test_reset;
    test_hold_high;
    test_fetch_row3;
    test_overlay;
    test_blank;
    test_busy_drop;
    test_commit_edge;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
